load_store_unit: RTL and testbench

- Parametrised multicycle load/store unit between the core datapath and the unified instruction/data memory.
- Adds memory writes, byte/half/word(/dword) accesses, byte enables, load sign/zero extension and a wait-state memory handshake with bus timeout.
- Core side uses a valid/ready request and a single-cycle response pulse.
- Memory side is a word-aligned request/acknowledge bus with byte enables.

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: core valid/ready request to a word-aligned memory bus with wait states and timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word/dword requests error out without touching memory.
module load_store_unit #(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int NB  = XLEN / 8;
   localparam int OFS = $clog2(NB);
   localparam int CW  = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic              trap_req;
   logic              timeout;

   logic              we_p1;
   logic [1:0]        size_p1;
   logic              uns_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [NB-1:0]     be_p1;
   logic [XLEN-1:0]   wdata_p1;
   logic [XLEN-1:0]   rdata_p2;
   logic              err_p2;

   // Lowest lane touched: offset bits below the access size are dropped.
   function automatic logic [OFS-1:0] lane_base(input logic [1:0] size, input logic [OFS-1:0] o);
      case (size)
         2'b00:   lane_base = o;
         2'b01:   lane_base = o & ~OFS'(1);
         2'b10:   lane_base = o & ~OFS'(3);
         default: lane_base = '0;
      endcase
   endfunction

   function automatic logic [NB-1:0] byte_en(input logic [1:0] size, input logic [OFS-1:0] o);
      case (size)
         2'b00:   byte_en = NB'(1) << o;
         2'b01:   byte_en = NB'(2'b11) << lane_base(size, o);
         2'b10:   byte_en = NB'(4'hF) << lane_base(size, o);
         default: byte_en = '1;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] replicate(input logic [1:0] size, input logic [XLEN-1:0] d);
      case (size)
         2'b00:   replicate = {NB{d[7:0]}};
         2'b01:   replicate = {(NB/2){d[15:0]}};
         2'b10:   replicate = {(NB/4){d[31:0]}};
         default: replicate = d;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] raw, input logic [1:0] size,
                                                input logic uns, input logic [OFS-1:0] o);
      logic [XLEN-1:0] sh;
      sh = raw >> {lane_base(size, o), 3'b000};
      fmt_load = raw;
      case (size)
         2'b00: begin
            fmt_load = XLEN'(sh[7:0]);
            for (int i = 8; i < XLEN; i++) fmt_load[i] = sh[7] & ~uns;
         end
         2'b01: begin
            fmt_load = XLEN'(sh[15:0]);
            for (int i = 16; i < XLEN; i++) fmt_load[i] = sh[15] & ~uns;
         end
         2'b10: begin
            fmt_load = XLEN'(sh[31:0]);
            for (int i = 32; i < XLEN; i++) fmt_load[i] = sh[31] & ~uns;
         end
         default: fmt_load = raw;
      endcase
   endfunction

   function automatic logic size_ok(input logic [1:0] size);
      size_ok = (XLEN == 64) || (size != 2'b11);
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [1:0] size, input logic [OFS-1:0] o);
      case (size)
         2'b01:   misaligned = o[0];
         2'b10:   misaligned = |o[1:0];
         2'b11:   misaligned = |o;
         default: misaligned = 1'b0;
      endcase
   endfunction

   assign trap_req = !size_ok(req_size) || misaligned(req_size, req_addr[OFS-1:0]);
`else
   assign trap_req = !size_ok(req_size);
`endif

   assign timeout = (cnt == CW'(MAX_WAIT - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE)
            cnt <= '0;
         else if (state == S_ACCESS && !mem_ack)
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      mem_req   = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = trap_req ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            mem_req = 1'b1;
            if (mem_ack || timeout) state_nx = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // p1: request captured on acceptance, held for the whole access
   always_ff @(posedge clk) begin
      if (state == S_IDLE && req_valid) begin
         we_p1    <= req_we;
         size_p1  <= req_size;
         uns_p1   <= req_unsigned;
         addr_p1  <= req_addr;
         be_p1    <= byte_en(req_size, req_addr[OFS-1:0]);
         wdata_p1 <= replicate(req_size, req_wdata);
         rdata_p2 <= '0;
         err_p2   <= trap_req;
      end
      // p2: response formed when the access leaves ACCESS
      if (state == S_ACCESS) begin
         if (mem_ack) begin
            rdata_p2 <= we_p1 ? '0 : fmt_load(mem_rdata, size_p1, uns_p1, addr_p1[OFS-1:0]);
            err_p2   <= 1'b0;
         end else if (timeout) begin
            rdata_p2 <= '0;
            err_p2   <= 1'b1;
         end
      end
   end

   assign rsp_rdata = rsp_valid ? rdata_p2 : '0;
   assign rsp_err   = rsp_valid & err_p2;
   assign mem_we    = mem_req & we_p1;
   assign mem_addr  = mem_req ? {addr_p1[ADDR_W-1:OFS], {OFS{1'b0}}} : '0;
   assign mem_be    = mem_req ? be_p1 : '0;
   assign mem_wdata = mem_req ? wdata_p1 : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (XLEN=32, MAX_WAIT=4): per-cycle timeline model plus literal pins.
// Honours LSU_MISALIGN_TRAP_EN when the same macro is defined for the build.
module tb_load_store_unit;
   localparam int MAX_WAIT = 4;
   localparam int DEPTH    = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   load_store_unit #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;
   bit chk_en = 0;

   // expected outputs for the interval following posedge number i
   logic        e_ready[DEPTH], e_mreq[DEPTH], e_mwe[DEPTH], e_rv[DEPTH], e_re[DEPTH];
   logic [31:0] e_maddr[DEPTH], e_mwd[DEPTH], e_rd[DEPTH];
   logic [3:0]  e_mbe[DEPTH];

   int          ack_n = -1, seen = 0;
   logic [31:0] mem_data_v = '0;
   int          rsp_cnt = 0, mreq_cnt = 0, last_rsp_cyc = 0, acc_cyc = 0;
   logic [31:0] last_rdata = '0, last_addr = '0, last_wdata = '0;
   logic [3:0]  last_be = '0;
   logic        last_err = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic set_idle(input int i);
      e_ready[i] = 1'b1; e_mreq[i] = 1'b0; e_mwe[i] = 1'b0; e_rv[i] = 1'b0; e_re[i] = 1'b0;
      e_maddr[i] = '0; e_mwd[i] = '0; e_rd[i] = '0; e_mbe[i] = '0;
   endtask

   // Model: spec rules written as plain byte arithmetic
   function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
      int n, start;
      n = 1 << size;
      start = ((addr % 4) / n) * n;
      return 4'(((1 << n) - 1) << start);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
      int n;
      logic [63:0] v, mask;
      n = 1 << size;
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = '0;
      for (int k = 0; k < 4 / n; k++) v = v | (({32'b0, d} & mask) << (8 * n * k));
      return v[31:0];
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] raw, input logic [1:0] size,
                                          input logic uns, input logic [31:0] addr);
      int n, start;
      logic [63:0] v, mask;
      n = 1 << size;
      start = ((addr % 4) / n) * n;
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = ({32'b0, raw} >> (8 * start)) & mask;
      if (!uns && v[8 * n - 1]) v = v - (64'd1 << (8 * n));
      return v[31:0];
   endfunction

   function automatic bit m_trap(input logic [1:0] size, input logic [31:0] addr);
      bit mis;
      mis = (addr % (32'd1 << size)) != 0;
`ifndef LSU_MISALIGN_TRAP_EN
      mis = 1'b0;
`endif
      return (size == 2'b11) || mis;
   endfunction

   // memory responder: ack after ack_n wait states (never if negative)
   always @(negedge clk) begin
      if (mem_req) begin
         mem_ack   = (ack_n >= 0) && (seen == ack_n);
         mem_rdata = mem_data_v;
         seen++;
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = 32'h5A5A_5A5A;
         seen      = 0;
      end
   end

   // compare process
   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", req_ready, e_ready[cyc]);
         check("mem_req",   mem_req,   e_mreq[cyc]);
         check("mem_we",    mem_we,    e_mwe[cyc]);
         check("mem_addr",  mem_addr,  e_maddr[cyc]);
         check("mem_be",    mem_be,    e_mbe[cyc]);
         check("mem_wdata", mem_wdata, e_mwd[cyc]);
         check("rsp_valid", rsp_valid, e_rv[cyc]);
         check("rsp_rdata", rsp_rdata, e_rd[cyc]);
         check("rsp_err",   rsp_err,   e_re[cyc]);
         if (rsp_valid) begin
            rsp_cnt++; last_rsp_cyc = cyc; last_rdata = rsp_rdata; last_err = rsp_err;
         end
         if (mem_req) begin
            mreq_cnt++; last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
         end
      end
   end

   // Issue one access from an IDLE negedge; returns at the next IDLE negedge.
   task automatic access(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_after, input logic [31:0] rdata, input bit do_reset);
      int a, l;
      logic [31:0] er;
      logic ee;
      mreq_cnt = 0;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      ack_n = ack_after; mem_data_v = rdata;
      a = cyc + 1;
      acc_cyc = a;
      if (m_trap(size, addr)) begin
         l = 0; ee = 1'b1; er = '0;
      end else if (ack_after < 0 || ack_after >= MAX_WAIT) begin
         l = MAX_WAIT; ee = 1'b1; er = '0;
      end else begin
         l = ack_after + 1; ee = 1'b0; er = we ? 32'h0 : m_load(rdata, size, uns, addr);
      end
      for (int k = 0; k < l; k++) begin
         e_ready[a+k] = 1'b0; e_mreq[a+k] = 1'b1; e_mwe[a+k] = we;
         e_maddr[a+k] = addr & ~32'h3; e_mbe[a+k] = m_be(size, addr);
         e_mwd[a+k] = m_wdata(size, wdata);
      end
      e_ready[a+l] = 1'b0; e_rv[a+l] = 1'b1; e_rd[a+l] = er; e_re[a+l] = ee;
      @(posedge clk);
      #1;
      if (do_reset) begin
         req_valid = 1'b0;
         @(negedge clk);
         @(negedge clk);
         reset = 1'b0;
         for (int k = a + 2; k <= a + l; k++) set_idle(k);
         @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
      end else begin
         req_valid = 1'b1; req_we = ~we; req_size = 2'b00; req_unsigned = ~uns;
         req_addr = ~addr; req_wdata = ~wdata;
         repeat (l + 1) @(negedge clk);
         req_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int saved;
      for (int i = 0; i < DEPTH; i++) set_idle(i);
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("rst_ready", req_ready, 1);
      check("rst_mreq", mem_req, 0);
      check("rst_rsp", rsp_valid, 0);
      reset = 1'b1;
      @(negedge clk);

      // store byte 0xA5 to 0x103, zero-wait
      access(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 0, 32'h0, 0);
      check("t1_addr", last_addr, 32'h100);
      check("t1_be", last_be, 4'b1000);
      check("t1_wdata", last_wdata, 32'hA5A5_A5A5);
      check("t1_lat", last_rsp_cyc - acc_cyc, 1);
      check("t1_err", last_err, 0);

      // half loads from 0x102, signed then unsigned
      access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 32'h8001_1234, 0);
      check("t2_rdata", last_rdata, 32'hFFFF_8001);
      access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 32'h8001_1234, 0);
      check("t3_rdata", last_rdata, 32'h0000_8001);

      // word load with 3 wait states: ack on the last allowed cycle wins
      access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0);
      check("t4_mreq_cycles", mreq_cnt, 4);
      check("t4_lat", last_rsp_cyc - acc_cyc, 4);
      check("t4_rdata", last_rdata, 32'hDEAD_BEEF);
      check("t4_err", last_err, 0);

      // no ack: timeout after MAX_WAIT cycles
      access(1'b0, 2'b10, 1'b0, 32'h240, 32'h0, -1, 32'h1111_2222, 0);
      check("t5_mreq_cycles", mreq_cnt, 4);
      check("t5_err", last_err, 1);
      check("t5_rdata", last_rdata, 0);
      check("t5_lat", last_rsp_cyc - acc_cyc, 4);

      // reset in the second ACCESS cycle abandons the access
      saved = rsp_cnt;
      access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, -1, 32'h0, 1);
      check("t6_no_rsp", rsp_cnt, saved);
      check("t6_mreq_cycles", mreq_cnt, 2);

      // illegal size with XLEN=32
      access(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 0, 32'h0, 0);
      check("t7_mreq_cycles", mreq_cnt, 0);
      check("t7_err", last_err, 1);
      check("t7_lat", last_rsp_cyc - acc_cyc, 0);

      // misaligned word load from 0x101
      access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h1122_3344, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("t8_mreq_cycles", mreq_cnt, 0);
      check("t8_err", last_err, 1);
      check("t8_lat", last_rsp_cyc - acc_cyc, 0);
`else
      check("t8_addr", last_addr, 32'h100);
      check("t8_be", last_be, 4'hF);
      check("t8_rdata", last_rdata, 32'h1122_3344);
      check("t8_lat", last_rsp_cyc - acc_cyc, 1);
`endif

      // more lane patterns
      access(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1, 32'h1234_80FF, 0);
      check("t9_rdata", last_rdata, 32'hFFFF_FF80);
      access(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 0, 32'h1234_80FF, 0);
      check("t10_rdata", last_rdata, 32'h0000_0080);
      access(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, 2, 32'h0, 0);
      check("t11_be", last_be, 4'b1100);
      check("t11_wdata", last_wdata, 32'hBEEF_BEEF);
      check("t11_rdata", last_rdata, 0);
      access(1'b1, 2'b10, 1'b0, 32'h200, 32'h1234_5678, 1, 32'h0, 0);
      check("t12_be", last_be, 4'hF);
      check("t12_wdata", last_wdata, 32'h1234_5678);
      access(1'b0, 2'b00, 1'b0, 32'h1FF, 32'h0, 0, 32'h7F00_0000, 0);
      check("t13_rdata", last_rdata, 32'h0000_007F);
      check("t13_addr", last_addr, 32'h1FC);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
